// File: rtl/sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sd_drive_arbiter
// Description : Shares one host SD block-transfer channel between up to four
//               emulated drives. Requests are granted round-robin one at a
//               time. The granted request is latched and presented to the host.
//               The host ack is routed back to the granted drive, and that
//               drive's write-buffer data is muxed onto the host port.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   DRIVES   number of requesting drives (clamped to 1..4 as NDR)
//   IDXW     width of grant_idx
//   TIMEOUT  watchdog limit in clk_sys cycles (SD_ARB_TIMEOUT_EN only)
// Ports
//   clk_sys, reset_n        clock, asynchronous active-low reset
//   drv_rd / drv_wr         per-drive level requests, held until drv_ack rises
//   drv_lba / drv_blk_cnt   per-drive LBA (32b) and block count - 1 (6b)
//   drv_buff_din            per-drive write-buffer data (8b)
//   drv_ack                 per-drive ack, routed from the host
//   sd_rd / sd_wr           host request strobes (level)
//   sd_lba / sd_blk_cnt     latched request parameters
//   sd_buff_din             write data of the granted drive (combinational)
//   sd_ack                  host ack
//   grant_idx               current or last granted drive
//   busy                    arbiter is not idle
//   timeout_err             one-cycle pulse on watchdog abort
// Optional feature
//   Define SD_ARB_TIMEOUT_EN to enable the watchdog that aborts a stuck
//   transaction after TIMEOUT cycles. Without it timeout_err is tied low and
//   the arbiter waits indefinitely for the host.
// ============================================================================
module sd_drive_arbiter #(
   parameter int          DRIVES  = 2,
   parameter int          IDXW    = 2,
   parameter logic [23:0] TIMEOUT = 24'd12000000,
   localparam int         NDR     = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES)
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [NDR-1:0]    drv_rd,
   input  logic [NDR-1:0]    drv_wr,
   input  logic [NDR*32-1:0] drv_lba,
   input  logic [NDR*6-1:0]  drv_blk_cnt,
   input  logic [NDR*8-1:0]  drv_buff_din,
   output logic [NDR-1:0]    drv_ack,
   output logic              sd_rd,
   output logic              sd_wr,
   output logic [31:0]       sd_lba,
   output logic [5:0]        sd_blk_cnt,
   output logic [7:0]        sd_buff_din,
   input  logic              sd_ack,
   output logic [IDXW-1:0]   grant_idx,
   output logic              busy,
   output logic              timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [1:0]       gidx, gidx_nx;
   logic [1:0]       rr_ptr, rr_ptr_nx;
   logic             sd_rd_nx, sd_wr_nx;
   logic [31:0]      sd_lba_nx;
   logic [5:0]       sd_blk_cnt_nx;
   logic [NDR-1:0]   drv_ack_nx;

   logic [NDR-1:0]   req;
   logic             found;
   logic [1:0]       pick;
   logic [31:0]      pick_lba;
   logic [5:0]       pick_cnt;
   logic             pick_rd;
   logic [1:0]       rr_adv;
   logic [NDR-1:0]   gnt_onehot;
   logic             abort;

   assign req       = drv_rd | drv_wr;
   assign busy      = (state != S_IDLE);
   assign grant_idx = IDXW'(gidx);

   // Round-robin search: offsets are scanned from the farthest to the
   // nearest so that the requester closest to rr_ptr is the last to be
   // written and therefore wins.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr;
      for (int k = NDR - 1; k >= 0; k--) begin
         for (int i = 0; i < NDR; i++) begin
            if (req[i] && (i == ((int'(rr_ptr) + k) % NDR))) begin
               found = 1'b1;
               pick  = 2'(i);
            end
         end
      end
   end

   // Parameters of the selected requester, captured on the IDLE->REQ edge.
   always_comb begin
      pick_lba = drv_lba[31:0];
      pick_cnt = drv_blk_cnt[5:0];
      pick_rd  = drv_rd[0];
      for (int i = 0; i < NDR; i++) begin
         if (pick == 2'(i)) begin
            pick_lba = drv_lba[32*i +: 32];
            pick_cnt = drv_blk_cnt[6*i +: 6];
            pick_rd  = drv_rd[i];
         end
      end
   end

   // Write data follows the grant in every state; buffer address and write
   // strobe are broadcast to the drives outside this block.
   always_comb begin
      sd_buff_din = drv_buff_din[7:0];
      for (int i = 0; i < NDR; i++) begin
         if (gidx == 2'(i)) begin
            sd_buff_din = drv_buff_din[8*i +: 8];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NDR; i++) begin
         gnt_onehot[i] = (gidx == 2'(i));
      end
   end

   // Next pointer skips past the drive just served (stays 0 when NDR = 1).
   assign rr_adv = (gidx == 2'(NDR - 1)) ? 2'd0 : (gidx + 2'd1);

   // Next-state and registered-output logic.
   always_comb begin
      state_nx      = state;
      gidx_nx       = gidx;
      rr_ptr_nx     = rr_ptr;
      sd_rd_nx      = sd_rd;
      sd_wr_nx      = sd_wr;
      sd_lba_nx     = sd_lba;
      sd_blk_cnt_nx = sd_blk_cnt;
      drv_ack_nx    = '0;

      if (abort) begin
         sd_rd_nx  = 1'b0;
         sd_wr_nx  = 1'b0;
         rr_ptr_nx = rr_adv;
         state_nx  = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               // Host ack is ignored here; it only matters once a request
               // has been issued.
               if (found) begin
                  gidx_nx       = pick;
                  sd_lba_nx     = pick_lba;
                  sd_blk_cnt_nx = pick_cnt;
                  // Read has priority; a pending write stays asserted by
                  // the drive and is served on a later grant.
                  sd_rd_nx      = pick_rd;
                  sd_wr_nx      = ~pick_rd;
                  state_nx      = S_REQ;
               end
            end
            S_REQ: begin
               // The drive may drop its request here; the host transaction
               // still runs to completion.
               if (sd_ack) begin
                  sd_rd_nx   = 1'b0;
                  sd_wr_nx   = 1'b0;
                  drv_ack_nx = gnt_onehot;
                  state_nx   = S_XFER;
               end
            end
            S_XFER: begin
               if (sd_ack) begin
                  drv_ack_nx = gnt_onehot;
               end else begin
                  rr_ptr_nx = rr_adv;
                  state_nx  = S_IDLE;
               end
            end
            default: begin
               sd_rd_nx = 1'b0;
               sd_wr_nx = 1'b0;
               state_nx = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         gidx       <= 2'd0;
         rr_ptr     <= 2'd0;
         sd_rd      <= 1'b0;
         sd_wr      <= 1'b0;
         sd_lba     <= 32'd0;
         sd_blk_cnt <= 6'd0;
         drv_ack    <= '0;
      end else begin
         state      <= state_nx;
         gidx       <= gidx_nx;
         rr_ptr     <= rr_ptr_nx;
         sd_rd      <= sd_rd_nx;
         sd_wr      <= sd_wr_nx;
         sd_lba     <= sd_lba_nx;
         sd_blk_cnt <= sd_blk_cnt_nx;
         drv_ack    <= drv_ack_nx;
      end
   end

`ifdef SD_ARB_TIMEOUT_EN
   // Watchdog: counts cycles spent in the current busy state and restarts
   // on every state change, so each phase of a transaction gets its own
   // TIMEOUT budget.
   logic [23:0] wd_cnt;

   assign abort = (state != S_IDLE) && (wd_cnt == (TIMEOUT - 24'd1));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt      <= 24'd0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= abort;
         if ((state_nx != state) || (state == S_IDLE)) begin
            wd_cnt <= 24'd0;
         end else begin
            wd_cnt <= wd_cnt + 24'd1;
         end
      end
   end
`else
   logic unused_timeout;

   assign abort          = 1'b0;
   assign timeout_err    = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

endmodule
`default_nettype wire
